// File: rtl/alu_seq.sv
// alu_seq: sequences one command at a time through an external 8-bit ALU.
// A command is accepted in IDLE. Its operands come from a 4 x 8 register file
// (operand B may be an immediate instead). They are presented to the ALU for
// SETTLE cycles, and the result and flags are captured one cycle later. The
// response is then held until the consumer takes it.
//
// State | Meaning
// IDLE    | cmd_ready high, waiting for a command
// ISSUE   | operands driven to the ALU, counting down SETTLE cycles
// CAPTURE | operands still driven; sample alu_z/flags, writeback, flag update
// RESP    | rsp_valid high, response held until rsp_ready
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_func, cmd_dst, cmd_srca, cmd_srcb, cmd_imm_en, cmd_imm   command fields
//   alu_a, alu_b, alu_func    operands and function code to the external ALU
//   alu_z, alu_sf/cf/zf/of    result and flags from the external ALU
//   rsp_valid/rsp_ready       response handshake
//   rsp_data, rsp_flags, rsp_err   result, flag register {SF,CF,ZF,OF}, bad-code
module alu_seq #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [4:0] cmd_func,
    input  logic [1:0] cmd_dst,
    input  logic [1:0] cmd_srca,
    input  logic [1:0] cmd_srcb,
    input  logic       cmd_imm_en,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [4:0] alu_func,
    input  logic [7:0] alu_z,
    input  logic       alu_sf,
    input  logic       alu_cf,
    input  logic       alu_zf,
    input  logic       alu_of,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [3:0] rsp_flags,
    output logic       rsp_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

    state_t     state, state_nx;
    logic [7:0] rf [4];
    logic [3:0] flags;
    logic [4:0] op_func;
    logic [1:0] op_dst;
    logic [7:0] op_a, op_b;
    logic [2:0] settle_cnt;
    logic [7:0] data_q;
    logic       err_q;

    logic op_wr, op_pack, op_flag, op_bad;

    // Function-code classes for the op currently latched.
    always_comb begin
        op_wr   = op_func inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd8, 5'd9,
                                  5'd10, 5'd11, 5'd12, 5'd15, 5'd16};
        op_pack = (op_func == 5'd7);
        op_flag = op_func inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10,
                                  5'd11, 5'd12, 5'd15, 5'd16, 5'd20};
        op_bad  = op_func inside {5'd13, 5'd14, 5'd17, 5'd18, 5'd19, [5'd21:5'd31]};
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_a     = 8'h00;
        alu_b     = 8'h00;
        alu_func  = 5'd0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = ISSUE;
            end
            ISSUE: begin
                alu_a    = op_a;
                alu_b    = op_b;
                alu_func = op_func;
                if (settle_cnt == 3'd0) state_nx = CAPTURE;
            end
            CAPTURE: begin
                alu_a    = op_a;
                alu_b    = op_b;
                alu_func = op_func;
                state_nx = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign rsp_data  = data_q;
    assign rsp_err   = err_q;
    assign rsp_flags = flags;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            for (int i = 0; i < 4; i++) rf[i] <= 8'h00;
            flags      <= 4'h0;
            op_func    <= 5'd0;
            op_dst     <= 2'd0;
            op_a       <= 8'h00;
            op_b       <= 8'h00;
            settle_cnt <= 3'd0;
            data_q     <= 8'h00;
            err_q      <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_func    <= cmd_func;
                        op_dst     <= cmd_dst;
                        op_a       <= rf[cmd_srca];
                        op_b       <= cmd_imm_en ? cmd_imm : rf[cmd_srcb];
                        // ISSUE lasts SETTLE cycles; leave when the count reaches zero.
                        settle_cnt <= 3'(SETTLE - 1);
                    end
                end
                ISSUE: begin
                    if (settle_cnt != 3'd0) settle_cnt <= settle_cnt - 3'd1;
                end
                CAPTURE: begin
                    if (op_bad) begin
                        data_q <= 8'h00;
                        err_q  <= 1'b1;
                    end else begin
                        data_q <= alu_z;
                        err_q  <= 1'b0;
                        if (op_wr || op_pack) rf[op_dst] <= alu_z;
                        // Pack's second write targets the partner register, never op_dst.
                        if (op_pack) rf[op_dst ^ 2'd1] <= op_b;
                        if (op_flag) flags <= {alu_sf, alu_cf, alu_zf, alu_of};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid, cmd_ready;
    logic [4:0] cmd_func;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic       cmd_imm_en;
    logic [7:0] cmd_imm;
    logic [7:0] alu_a, alu_b;
    logic [4:0] alu_func;
    logic [7:0] alu_z;
    logic       alu_sf, alu_cf, alu_zf, alu_of;
    logic       rsp_valid, rsp_ready;
    logic [7:0] rsp_data;
    logic [3:0] rsp_flags;
    logic       rsp_err;

    alu_seq #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_func(cmd_func), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm_en(cmd_imm_en), .cmd_imm(cmd_imm),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func),
        .alu_z(alu_z), .alu_sf(alu_sf), .alu_cf(alu_cf), .alu_zf(alu_zf), .alu_of(alu_of),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {z, SF, CF, ZF, OF}.
    function automatic logic [11:0] alu_ref(input logic [4:0] f, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] w;
        logic [7:0] z;
        logic       c, o;
        c = 1'b0; o = 1'b0; w = 9'd0;
        case (f)
            5'd1: begin w = {1'b0, a} + {1'b0, b}; z = w[7:0]; c = w[8];
                        o = (a[7] == b[7]) && (z[7] != a[7]); end
            5'd2, 5'd20: begin w = {1'b0, a} - {1'b0, b}; z = w[7:0]; c = w[8];
                        o = (a[7] != b[7]) && (z[7] != a[7]); end
            5'd3:  z = a & b;
            5'd4:  z = a | b;
            5'd5:  z = a ^ b;
            5'd6:  z = b;
            5'd7:  z = a;
            5'd8:  z = ~a;
            5'd9:  begin z = {a[6:0], 1'b0}; c = a[7]; end
            5'd10: begin z = {1'b0, a[7:1]}; c = a[0]; end
            5'd11: z = {a[6:0], a[7]};
            5'd12: z = {a[0], a[7:1]};
            5'd15: begin z = a + 8'd1; o = (a == 8'h7F); c = (a == 8'hFF); end
            5'd16: begin z = a - 8'd1; o = (a == 8'h80); c = (a == 8'h00); end
            default: z = 8'hA5 ^ a;
        endcase
        return {z, z[7], c, (z == 8'h00), o};
    endfunction

    always_comb {alu_z, alu_sf, alu_cf, alu_zf, alu_of} = alu_ref(alu_func, alu_a, alu_b);

    typedef struct {
        logic [7:0] data;
        logic [3:0] flags;
        logic       err;
        logic [7:0] a, b;
        logic [4:0] f;
        int         cyc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mr [4];
    logic [3:0] mflags;
    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    bit         seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    endtask

    task automatic bail(input string n);
        miscompares++;
        $display("FAIL %s: timeout waiting for DUT (cycle %0d)", n, cyc);
        finish_run();
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mflags = 4'h0;
        q.delete();
    endtask

    // Reference behaviour for one accepted command; returns the expected response.
    function automatic exp_t model_cmd(input logic [4:0] f, input logic [1:0] d, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic ie, input logic [7:0] im);
        exp_t       e;
        logic [11:0] r;
        e.a = mr[sa];
        e.b = ie ? im : mr[sb];
        e.f = f;
        e.cyc = cyc;
        if (f inside {5'd13, 5'd14, 5'd17, 5'd18, 5'd19} || f >= 5'd21) begin
            e.data = 8'h00;
            e.err  = 1'b1;
        end else begin
            r = alu_ref(f, e.a, e.b);
            e.data = r[11:4];
            e.err  = 1'b0;
            if (f inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd9, 5'd10, 5'd11, 5'd12, 5'd15, 5'd16, 5'd20})
                mflags = r[3:0];
            if (f inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd15, 5'd16})
                mr[d] = r[11:4];
            if (f == 5'd7) mr[d ^ 2'd1] = e.b;
        end
        e.flags = mflags;
        return e;
    endfunction

    // Offer a command and wait until it is accepted; pushes the expected response.
    task automatic send(input logic [4:0] f, input logic [1:0] d, input logic [1:0] sa,
                        input logic [1:0] sb, input logic ie, input logic [7:0] im);
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_func = f; cmd_dst = d; cmd_srca = sa; cmd_srcb = sb;
        cmd_imm_en = ie; cmd_imm = im; rsp_ready = 1'b0;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (cmd_ready) break;
            if (t > 40) bail("accept");
        end
        q.push_back(model_cmd(f, d, sa, sb, ie, im));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Wait for the response to drain, with rsp_ready low for the first 'stall' cycles,
    // and junk commands offered while the DUT is busy.
    task automatic drain(input int stall);
        for (int t = 0; ; t++) begin
            if (q.size() == 0) break;
            if (t > 60) bail("response");
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_func   = 5'($urandom);
            cmd_dst    = 2'($urandom);
            cmd_srca   = 2'($urandom);
            cmd_srcb   = 2'($urandom);
            cmd_imm_en = 1'($urandom);
            cmd_imm    = 8'($urandom);
            rsp_ready  = (t < stall) ? 1'b0 : ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic op(input logic [4:0] f, input logic [1:0] d, input logic [1:0] sa,
                      input logic [1:0] sb, input logic ie, input logic [7:0] im, input int stall);
        send(f, d, sa, sb, ie, im);
        drain(stall);
    endtask

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else begin
            if (rsp_valid && cmd_ready) chk("ready_valid_overlap", 1, 0);
            if (cmd_ready || rsp_valid)
                chk("alu_idle_zero", {alu_func, alu_a, alu_b}, 21'd0);
            if (rsp_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp", {rsp_err, rsp_data}, 9'h1FF);
                    miscompares++;
                    $display("FAIL unexpected_rsp: response with none pending (cycle %0d)", cyc);
                end else begin
                    chk("rsp", {rsp_err, rsp_flags, rsp_data}, {q[0].err, q[0].flags, q[0].data});
                    if (!seen) chk("latency", cyc - q[0].cyc, SETTLE + 2);
                    seen = 1;
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        seen = 0;
                    end
                end
            end else if (q.size() != 0 && cyc > q[0].cyc) begin
                chk("alu_drive", {cmd_ready, alu_func, alu_a, alu_b}, {1'b0, q[0].f, q[0].a, q[0].b});
            end
        end
    end

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_func = 5'd0; cmd_dst = 2'd0; cmd_srca = 2'd0;
        cmd_srcb = 2'd0; cmd_imm_en = 1'b0; cmd_imm = 8'h00; rsp_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {cmd_ready, rsp_valid, rsp_err, rsp_flags, rsp_data},
            {1'b1, 1'b0, 1'b0, 4'h0, 8'h00});

        // Pass B of 0x7F into R0, then increment R0 (signed overflow).
        op(5'd6, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 0);
        op(5'd15, 2'd0, 2'd0, 2'd0, 1'b0, 8'h00, 0);
        // Compare leaves R1 alone; read it back afterwards.
        op(5'd6, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0);
        op(5'd20, 2'd1, 2'd1, 2'd0, 1'b1, 8'h05, 0);
        op(5'd20, 2'd0, 2'd1, 2'd0, 1'b1, 8'h00, 0);
        // Pack into R2/R3.
        op(5'd6, 2'd2, 2'd0, 2'd0, 1'b1, 8'h12, 0);
        op(5'd6, 2'd3, 2'd0, 2'd0, 1'b1, 8'h34, 0);
        op(5'd7, 2'd2, 2'd2, 2'd3, 1'b0, 8'h00, 0);
        op(5'd20, 2'd0, 2'd2, 2'd0, 1'b1, 8'h00, 0);
        op(5'd20, 2'd0, 2'd3, 2'd0, 1'b1, 8'h00, 0);
        // Unsupported code, then a long stall with junk commands offered.
        op(5'd13, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 0);
        op(5'd1, 2'd0, 2'd2, 2'd3, 1'b0, 8'h00, SETTLE + 1 + 5);

        for (int i = 0; i < 200; i++)
            op(5'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
               1'($urandom), 8'($urandom), $urandom_range(0, 4));

        // Reset at each point of an in-flight add into R0.
        for (int d = 1; d <= SETTLE + 3; d++) begin
            op(5'd6, 2'd0, 2'd0, 2'd0, 1'b1, 8'($urandom_range(1, 255)), 0);
            send(5'd1, 2'd0, 2'd0, 2'd0, 1'b1, 8'h03);
            repeat (d - 1) @(posedge clk);
            #1 rst = 1'b1;
            model_reset();
            @(posedge clk);
            #1 rst = 1'b0;
            @(negedge clk);
            chk("ready_after_rst", {cmd_ready, rsp_valid, rsp_flags}, {1'b1, 1'b0, 4'h0});
            op(5'd20, 2'd0, 2'd0, 2'd0, 1'b1, 8'h00, 0);
        end

        repeat (5) @(posedge clk);
        finish_run();
    end

endmodule
